// File: rtl/baggage_drop_seq.sv
// Baggage-drop measurement sequencer: sensor average, serial sqrt, drop decision.
// Optional zero-reading sensor fault handling is enabled with SENSOR_FAULT_EN.
module baggage_drop_seq #(
   parameter int DROP_HOLD = 16,
   parameter int CNT_W     = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  sensor1,
   input  logic [7:0]  sensor2,
   input  logic [7:0]  sensor3,
   input  logic [7:0]  sensor4,
   input  logic [15:0] t_lim,
   input  logic        drop_en,
   output logic        busy,
   output logic        result_valid,
   output logic [15:0] t_act,
   output logic        drop_activated,
   output logic        fault
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAPTURE,
      S_SQRT,
      S_DECIDE,
      S_HOLD
   } state_t;

   state_t state, state_nx;

   logic [23:0]      rad;
   logic [13:0]      rem;
   logic [11:0]      root;
   logic [3:0]       step;
   logic [CNT_W-1:0] hold_cnt;
   logic             rv;

   logic [9:0]  sum;
   logic [7:0]  avg;
   logic [15:0] rem_sh;
   logic [15:0] trial;
   logic        ge;
   logic [15:0] rem_sub;
   logic [15:0] t_new;
   logic        decide;
   logic        hold_last;
   logic        bad_cap;

   assign sum = {2'b00, sensor1} + {2'b00, sensor2}
              + {2'b00, sensor3} + {2'b00, sensor4};

`ifdef SENSOR_FAULT_EN
   logic [8:0] p13;
   logic [8:0] p24;
   logic       bad13;
   logic       bad24;
   logic       fault_pend;
   logic       fault_r;

   assign p13   = {1'b0, sensor1} + {1'b0, sensor3};
   assign p24   = {1'b0, sensor2} + {1'b0, sensor4};
   assign bad13 = (sensor1 == 8'd0) || (sensor3 == 8'd0);
   assign bad24 = (sensor2 == 8'd0) || (sensor4 == 8'd0);

   always_comb begin
      avg = sum[9:2];
      if (bad13) begin
         avg = p24[8:1];
      end else if (bad24) begin
         avg = p13[8:1];
      end
   end

   assign bad_cap = bad13 && bad24;

   // Fault is latched at capture but only exposed from DECIDE onward.
   always_ff @(posedge clk) begin
      if (rst) begin
         fault_pend <= 1'b0;
         fault_r    <= 1'b0;
      end else begin
         if (state == S_IDLE && start) begin
            fault_r <= 1'b0;
         end
         if (state == S_CAPTURE) begin
            fault_pend <= bad_cap;
         end
         if (state == S_DECIDE) begin
            fault_r <= fault_pend;
         end
      end
   end

   assign fault  = fault_r;
   assign t_new  = fault_pend ? 16'd0 : {5'd0, root[11:1]};
   assign decide = drop_en && !fault_pend && (t_new <= t_lim);
`else
   assign avg     = sum[9:2];
   assign bad_cap = 1'b0;
   assign fault   = 1'b0;
   assign t_new   = {5'd0, root[11:1]};
   assign decide  = drop_en && (t_new <= t_lim);
`endif

   // One restoring square-root step: bring down two radicand bits.
   assign rem_sh  = {rem, rad[23:22]};
   assign trial   = {2'b00, root, 2'b01};
   assign ge      = rem_sh >= trial;
   assign rem_sub = rem_sh - trial;

   assign hold_last = hold_cnt == CNT_W'(DROP_HOLD - 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: begin
            if (start) state_nx = S_CAPTURE;
         end
         S_CAPTURE: state_nx = S_SQRT;
         S_SQRT: begin
            if (step == 4'd11) state_nx = S_DECIDE;
         end
         S_DECIDE: state_nx = decide ? S_HOLD : S_IDLE;
         S_HOLD: begin
            if (hold_last) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rad      <= '0;
         rem      <= '0;
         root     <= '0;
         step     <= '0;
         hold_cnt <= '0;
         t_act    <= '0;
         rv       <= 1'b0;
      end else begin
         rv <= 1'b0;
         unique case (state)
            S_CAPTURE: begin
               rad  <= {avg, 16'h0000};
               rem  <= '0;
               root <= '0;
               step <= '0;
            end
            S_SQRT: begin
               rad  <= {rad[21:0], 2'b00};
               rem  <= ge ? rem_sub[13:0] : rem_sh[13:0];
               root <= {root[10:0], ge};
               step <= step + 4'd1;
            end
            S_DECIDE: begin
               t_act    <= t_new;
               rv       <= 1'b1;
               hold_cnt <= '0;
            end
            S_HOLD: begin
               hold_cnt <= hold_cnt + CNT_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

   assign busy           = state != S_IDLE;
   assign result_valid   = rv;
   assign drop_activated = state == S_HOLD;

endmodule

// File: doc/baggage_drop_seq.md
Name: baggage_drop_seq

Overview:
Sequential controller for the baggage-drop measurement path. On a start request it captures the four height sensors, averages them, and runs a multicycle bit-serial square root. It then derives the drop time t_act = sqrt/2 and compares it with t_lim. If drop_en allows, it asserts drop_activated for a programmable hold time. It replaces the purely combinational chain with a fixed-latency, handshaked sequence and registered outputs.

Parameters:
DROP_HOLD, 16, number of cycles drop_activated stays high once a drop is decided (legal range >= 1)
CNT_W, 16, width of the hold counter (must hold DROP_HOLD)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a measurement; sampled only in IDLE
sensor1  input  8  sensor reading
sensor2  input  8  sensor reading
sensor3  input  8  sensor reading
sensor4  input  8  sensor reading
t_lim  input  16  time limit, Q8.8, same units as t_act
drop_en  input  1  drop permission, sampled in DECIDE
busy  output  1  high from the cycle after start is accepted until return to IDLE
result_valid  output  1  one-cycle pulse when t_act and the decision are final
t_act  output  16  computed drop time, Q8.8, held until the next result
drop_activated  output  1  drop command
fault  output  1  sensor fault flag (feature-dependent, see Optional Feature)

Behaviour:
- Reset: state=IDLE; busy, result_valid, drop_activated, fault=0; t_act=0; internal root, remainder, and counters cleared. Reset mid-operation aborts the sequence immediately, with no residual pulse.
- IDLE: start=1 -> CAPTURE. Otherwise stay.
- CAPTURE (1 cycle): latch the sensors. sum = zero-extended 10-bit sum of all four; avg = sum>>2 (truncate, 8 bits). Radicand R = {avg,16'h0000} (24 bits). -> SQRT.
- SQRT (exactly 12 cycles): restoring bit-serial integer square root, one root bit per cycle, MSB first. root = floor(sqrt(R)), 12 bits, which equals sqrt(avg) in Q8.8. -> DECIDE.
- DECIDE (1 cycle): t_act <= {4'b0,root}>>1. decide = drop_en && (t_act_new <= t_lim), an unsigned compare. -> HOLD if decide, else IDLE.
- result_valid is high in the cycle after DECIDE, i.e. exactly 15 cycles after the cycle in which start was sampled high.
- drop_activated rises together with result_valid. It stays high for exactly DROP_HOLD cycles, then falls, and the block returns to IDLE.
- busy is high for the whole of CAPTURE..HOLD and drops in the cycle IDLE is re-entered. start is ignored while busy, with no queuing.
- A new start may be accepted in the first IDLE cycle after busy falls.
- Sensor or t_lim changes after CAPTURE (sensors) or DECIDE (t_lim) do not affect the current result.
- fault=0 always when the optional feature is absent.

Optional Feature:
Macro SENSOR_FAULT_EN.
- Defined: a zero reading marks a sensor faulty.
  - If sensor1 or sensor3 is 0, avg = (sensor2+sensor4)>>1.
  - Else if sensor2 or sensor4 is 0, avg = (sensor1+sensor3)>>1.
  - If both pairs contain a zero: fault=1 from DECIDE until the next accepted start, t_act=0, no drop, result_valid still pulses.
- Undefined: plain four-sensor average, fault tied 0.

Test Plan:
- All sensors=64, t_lim=16'd1024, drop_en=1, start pulse -> result_valid exactly 15 cycles later, t_act=1024, drop_activated high for exactly DROP_HOLD cycles, busy then falls.
- All sensors=64, t_lim=1023, drop_en=1 -> t_act=1024, drop_activated stays 0, IDLE the cycle after result_valid.
- All sensors=255, t_lim=16'hFFFF, drop_en=0 -> t_act=2043 (root 4087), no drop. Then all sensors=100 -> t_act=1280.
- start held high continuously through one sequence -> exactly one sequence per IDLE visit, no start accepted while busy=1.
- rst asserted during SQRT cycle 6 -> next cycle all outputs 0 and state IDLE; a fresh start gives a correct 15-cycle result.
- With SENSOR_FAULT_EN: sensor1=0, sensor2=sensor4=64 -> t_act=1024, fault=0. With sensor1=0 and sensor2=0 -> fault=1, t_act=0, no drop.
